// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states, MEM/WB record.
// Pure declarations; no timing or flow-control behaviour of its own.
package mem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam int TIMEOUT_CYC_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] alu_rslt;
        logic [31:0] rdata;
    } memwb_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, misalignment detect, load shift and sign/zero extend.
// Purely combinational; no flow control.
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] st_data_o,
    output logic [31:0] ld_data_o,
    output logic        misalign_o
);

    logic [15:0] ld_sh;

    // Only the low 16 bits of the shifted word can ever reach a sub-word load.
    always_comb begin
        ld_sh = 16'h0000;
        case (addr_lo_i)
            2'd0:    ld_sh = ld_data_i[15:0];
            2'd1:    ld_sh = ld_data_i[23:8];
            2'd2:    ld_sh = ld_data_i[31:16];
            default: ld_sh = {8'h00, ld_data_i[31:24]};
        endcase
    end

    always_comb begin
        be_o       = 4'hF;
        st_data_o  = st_data_i;
        ld_data_o  = ld_data_i;
        misalign_o = 1'b0;
        case (size_i[1:0])
            2'b00: begin
                be_o       = 4'b0001 << addr_lo_i;
                st_data_o  = {4{st_data_i[7:0]}};
                ld_data_o  = size_i[2] ? {24'h000000, ld_sh[7:0]}
                                       : {{24{ld_sh[7]}}, ld_sh[7:0]};
            end
            2'b01: begin
                be_o       = 4'b0011 << addr_lo_i;
                st_data_o  = {2{st_data_i[15:0]}};
                ld_data_o  = size_i[2] ? {16'h0000, ld_sh}
                                       : {{16{ld_sh[15]}}, ld_sh};
                misalign_o = addr_lo_i[0];
            end
            default: begin
                misalign_o = |addr_lo_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: load/store over a req/gnt/rvalid bus, owns the MEM/WB register (latency 1 edge per completion).
// Holds upstream via stall_o while an access is outstanding; MEM/WB takes bubbles meanwhile.
module mem_access
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_rst_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [4:0]  rd_i,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic        memtoreg_i,
    input  logic        regwrite_i,
    input  logic [2:0]  size_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic [4:0]  wb_rd_o,
    output logic        wb_regwrite_o,
    output logic        wb_memtoreg_o,
    output logic [31:0] wb_alu_rslt_o,
    output logic [31:0] wb_rdata_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);
    localparam logic        TO_EN  = (TIMEOUT_CYC != 0);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    memwb_t      wb_q, wb_d;

    logic        is_memop, is_store;
    logic        lane_misal;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, ld_ext;
    logic        to_hit;
    logic        req, stall, misal_p, berr_p;
    memwb_t      op_wb;

    assign is_memop = memread_i | memwrite_i;
    assign is_store = memwrite_i;
    assign to_hit   = TO_EN && (cnt_q == TO_LIM);

    lsu_align u_align (
        .addr_lo_i  (alu_rst_i[1:0]),
        .size_i     (size_i),
        .st_data_i  (mem_wdata_i),
        .ld_data_i  (dmem_rdata_i),
        .be_o       (lane_be),
        .st_data_o  (lane_wdata),
        .ld_data_o  (ld_ext),
        .misalign_o (lane_misal)
    );

    always_comb begin
        state_d = state_q;
        wb_d    = '0;
        req     = 1'b0;
        stall   = 1'b0;
        misal_p = 1'b0;
        berr_p  = 1'b0;
        op_wb   = '{rd: rd_i, regwrite: regwrite_i, memtoreg: memtoreg_i,
                    alu_rslt: alu_rst_i, rdata: 32'h0};

        case (state_q)
            IDLE: begin
                if (!is_memop) begin
                    wb_d = op_wb;
                end else if (lane_misal) begin
                    misal_p = 1'b1;
                end else begin
                    req = 1'b1;
                    if (dmem_gnt_i && is_store) begin
                        wb_d = op_wb;
                    end else if (dmem_gnt_i) begin
                        state_d = RESP;
                        stall   = 1'b1;
                    end else begin
                        state_d = REQ;
                        stall   = 1'b1;
                    end
                end
            end
            REQ: begin
                if (to_hit) begin
                    berr_p  = 1'b1;
                    state_d = IDLE;
                end else begin
                    req = 1'b1;
                    if (dmem_gnt_i && is_store) begin
                        wb_d    = op_wb;
                        state_d = IDLE;
                    end else if (dmem_gnt_i) begin
                        state_d = RESP;
                        stall   = 1'b1;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            RESP: begin
                // A response arriving in the timeout cycle still wins.
                if (dmem_rvalid_i) begin
                    wb_d       = op_wb;
                    wb_d.rdata = ld_ext;
                    state_d    = IDLE;
                end else if (to_hit) begin
                    berr_p  = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cnt_d = (state_q != IDLE && state_d != IDLE) ? cnt_q + 16'd1 : 16'd0;

        if (rst) begin
            req     = 1'b0;
            stall   = 1'b0;
            misal_p = 1'b0;
            berr_p  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
        end
    end

    assign dmem_req_o    = req;
    assign dmem_we_o     = req & is_store;
    assign dmem_addr_o   = req ? {alu_rst_i[31:2], 2'b00} : 32'h0;
    assign dmem_be_o     = req ? lane_be : 4'h0;
    assign dmem_wdata_o  = (req && is_store) ? lane_wdata : 32'h0;
    assign stall_o       = stall;
    assign misalign_o    = misal_p;
    assign bus_err_o     = berr_p;

    assign wb_rd_o       = wb_q.rd;
    assign wb_regwrite_o = wb_q.regwrite;
    assign wb_memtoreg_o = wb_q.memtoreg;
    assign wb_alu_rslt_o = wb_q.alu_rslt;
    assign wb_rdata_o    = wb_q.rdata;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: scoreboard of MEM/WB results plus bus-side checks.
// Instance a uses the default timeout, instance b a short one for abort tests.
module tb_mem_access;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu, wdat;
    logic [4:0]  rd;
    logic        mr, mw, m2r, rw;
    logic [2:0]  sz;
    logic        gnt, rvalid;
    logic [31:0] rdata;

    logic        a_req, a_we, a_stall, a_wb_rw, a_wb_m2r, a_mis, a_berr;
    logic [31:0] a_addr, a_wdata, a_wb_alu, a_wb_rdata;
    logic [3:0]  a_be;
    logic [4:0]  a_wb_rd;
    logic        b_req, b_we, b_stall, b_wb_rw, b_wb_m2r, b_mis, b_berr;
    logic [31:0] b_addr, b_wdata, b_wb_alu, b_wb_rdata;
    logic [3:0]  b_be;
    logic [4:0]  b_wb_rd;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_access u_a (
        .clk(clk), .rst(rst), .alu_rst_i(alu), .mem_wdata_i(wdat), .rd_i(rd),
        .memread_i(mr), .memwrite_i(mw), .memtoreg_i(m2r), .regwrite_i(rw), .size_i(sz),
        .dmem_req_o(a_req), .dmem_we_o(a_we), .dmem_addr_o(a_addr), .dmem_be_o(a_be),
        .dmem_wdata_o(a_wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
        .stall_o(a_stall), .wb_rd_o(a_wb_rd), .wb_regwrite_o(a_wb_rw), .wb_memtoreg_o(a_wb_m2r),
        .wb_alu_rslt_o(a_wb_alu), .wb_rdata_o(a_wb_rdata), .misalign_o(a_mis), .bus_err_o(a_berr)
    );

    mem_access #(.TIMEOUT_CYC(4)) u_b (
        .clk(clk), .rst(rst), .alu_rst_i(alu), .mem_wdata_i(wdat), .rd_i(rd),
        .memread_i(mr), .memwrite_i(mw), .memtoreg_i(m2r), .regwrite_i(rw), .size_i(sz),
        .dmem_req_o(b_req), .dmem_we_o(b_we), .dmem_addr_o(b_addr), .dmem_be_o(b_be),
        .dmem_wdata_o(b_wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
        .stall_o(b_stall), .wb_rd_o(b_wb_rd), .wb_regwrite_o(b_wb_rw), .wb_memtoreg_o(b_wb_m2r),
        .wb_alu_rslt_o(b_wb_alu), .wb_rdata_o(b_wb_rdata), .misalign_o(b_mis), .bus_err_o(b_berr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                         input logic read, input logic write, input logic tor,
                         input logic wr, input logic [2:0] s);
        alu = a; wdat = d; rd = r; mr = read; mw = write; m2r = tor; rw = wr; sz = s;
    endtask

    task automatic nop();
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, SZ_B);
    endtask

    task automatic push_exp(input logic [4:0] r, input logic w, input logic m,
                            input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.rd = r; e.rw = w; e.m2r = m; e.alu = a; e.rdata = d;
        sb.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        chk({tag, "_sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_wb_rd"},       a_wb_rd,    e.rd);
            chk({tag, "_wb_regwrite"}, a_wb_rw,    e.rw);
            chk({tag, "_wb_memtoreg"}, a_wb_m2r,   e.m2r);
            chk({tag, "_wb_alu"},      a_wb_alu,   e.alu);
            chk({tag, "_wb_rdata"},    a_wb_rdata, e.rdata);
        end
    endtask

    // gnt in cycle 2, rvalid in cycle 5 -> five stalled cycles.
    task automatic load_seq(input string tag, input logic [2:0] s, input logic [31:0] expd);
        int nst = 0;
        drive(32'h102, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, s);
        for (int c = 0; c < 6; c++) begin
            gnt    = (c == 2);
            rvalid = (c == 5);
            rdata  = (c == 5) ? 32'h0080_0000 : 32'h0;
            #1;
            if (a_stall) nst++;
            chk({tag, "_req"}, a_req, (c <= 2));
            if (c == 5) push_exp(5'd7, 1'b1, 1'b1, 32'h102, expd);
            tick();
            if (c < 5) chk({tag, "_bubble"}, a_wb_rw, 1'b0);
        end
        gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        nop();
        sb_check(tag);
        chk({tag, "_stall_cycles"}, nst, 5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        nop();
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_wb_regwrite", a_wb_rw, 1'b0);
        chk("rst_wb_alu",      a_wb_alu, 32'h0);
        chk("rst_req",         a_req, 1'b0);
        chk("rst_stall",       a_stall, 1'b0);

        // ALU op passes straight to MEM/WB
        drive(32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, SZ_W);
        #1;
        chk("alu_stall", a_stall, 1'b0);
        chk("alu_req",   a_req, 1'b0);
        push_exp(5'd5, 1'b1, 1'b0, 32'h1234, 32'h0);
        tick();
        nop();
        sb_check("alu");

        // SB with immediate grant
        drive(32'h103, 32'hAB, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, SZ_B);
        gnt = 1'b1;
        #1;
        chk("sb_req",   a_req, 1'b1);
        chk("sb_we",    a_we, 1'b1);
        chk("sb_be",    a_be, 4'b1000);
        chk("sb_wdata", a_wdata, 32'hABAB_ABAB);
        chk("sb_addr",  a_addr, 32'h100);
        chk("sb_stall", a_stall, 1'b0);
        push_exp(5'd0, 1'b0, 1'b0, 32'h103, 32'h0);
        tick();
        gnt = 1'b0;
        nop();
        sb_check("sb");

        // SH at upper half, grant one cycle late
        drive(32'h0000_0102, 32'h1234_BEEF, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, SZ_H);
        #1;
        chk("sh_stall0", a_stall, 1'b1);
        chk("sh_be",     a_be, 4'b1100);
        chk("sh_wdata",  a_wdata, 32'hBEEF_BEEF);
        tick();
        chk("sh_bubble", a_wb_rw, 1'b0);
        gnt = 1'b1;
        #1;
        chk("sh_req1",   a_req, 1'b1);
        chk("sh_stall1", a_stall, 1'b0);
        push_exp(5'd2, 1'b1, 1'b0, 32'h102, 32'h0);
        tick();
        gnt = 1'b0;
        nop();
        sb_check("sh");

        load_seq("lb",  SZ_B,  32'hFFFF_FF80);
        load_seq("lbu", SZ_BU, 32'h0000_0080);

        // Misaligned word and half: dropped with a 1-cycle pulse
        drive(32'h102, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, SZ_W);
        #1;
        chk("lw_mis_req",   a_req, 1'b0);
        chk("lw_mis_pulse", a_mis, 1'b1);
        chk("lw_mis_stall", a_stall, 1'b0);
        push_exp(5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        drive(32'h101, 32'h0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, SZ_HU);
        #1;
        sb_check("lw_mis");
        chk("sh_mis_pulse", a_mis, 1'b1);
        chk("sh_mis_req",   a_req, 1'b0);
        tick();
        nop();
        #1;
        chk("mis_pulse_end", a_mis, 1'b0);

        // Timeout on instance b (limit 4): granted load, no response
        drive(32'h200, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, SZ_W);
        for (int c = 0; c < 6; c++) begin
            gnt = (c == 0);
            #1;
            chk("to_stall",   b_stall, (c < 5));
            chk("to_bus_err", b_berr,  (c == 5));
            tick();
            chk("to_bubble", b_wb_rw, 1'b0);
        end
        gnt = 1'b0;
        nop();
        #1;
        chk("to_err_end", b_berr, 1'b0);
        chk("to_req_idle", b_req, 1'b0);
        tick();
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        #1;
        chk("to_late_stall", b_stall, 1'b0);
        tick();
        rvalid = 1'b0; rdata = 32'h0;
        chk("to_late_rdata", b_wb_rdata, 32'h0);
        chk("to_late_rw",    b_wb_rw, 1'b0);

        // Reset while a load waits for its response on instance a
        drive(32'h300, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, SZ_W);
        gnt = 1'b1;
        #1;
        chk("rr_req", a_req, 1'b1);
        tick();
        gnt = 1'b0;
        rst = 1'b1;
        #1;
        chk("rr_stall_in_rst", a_stall, 1'b0);
        chk("rr_req_in_rst",   a_req, 1'b0);
        tick();
        rvalid = 1'b1; rdata = 32'h1234_5678;
        #1;
        chk("rr_req_after", a_req, 1'b0);
        tick();
        rst = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        nop();
        #1;
        chk("rr_wb_rdata", a_wb_rdata, 32'h0);
        chk("rr_wb_rw",    a_wb_rw, 1'b0);
        chk("rr_stall",    a_stall, 1'b0);
        chk("rr_req_idle", a_req, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
